clk_en_period_meter: RTL and testbench

Receive-side companion to the team's clock-enable dividers. It watches an incoming single-cycle enable strobe and measures the strobe period in clk cycles, then declares lock once the period is stable. It flags loss of strobe with a timeout and counts strobes. It sits downstream of any divider/enable generator, for self-check and for rate recovery.

---
 rtl/clk_en_period_meter.sv | 161 ++++++++++++++++
 tb/tb_clk_en_period_meter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_period_meter.sv
// ---------------------------------------------------------------------------
// clk_en_period_meter
//
// Purpose:
//   Receive-side companion to the clock-enable dividers. Watches a
//   single-cycle enable strobe, measures the distance between rising edges
//   in clk cycles, declares lock once LOCK_CNT consecutive periods agree,
//   flags strobe loss with a timeout pulse and keeps a 4-bit strobe count.
//
// Optional feature (compile-time macro):
//   PERIOD_JITTER_TOL_EN - when defined, a period "matches" the lock
//   reference if it differs by at most one cycle; the reference is then
//   left untouched so it cannot drift. When undefined, a match requires
//   exact equality.
//
// Parameters:
//   CNT_W    - width of the gap counter and of the period output
//   LOCK_CNT - consecutive equal periods needed for lock (2..15)
//   TIMEOUT  - cycles without an edge before timeout (<= 2^CNT_W-1)
//
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous, active-low reset
//   en_in        in   incoming enable strobe (rising edge significant)
//   period       out  last measured edge-to-edge distance, clk cycles
//   period_valid out  one-cycle pulse whenever period is updated
//   locked       out  high while the period is stable
//   timeout_err  out  one-cycle pulse on strobe loss
//   strobe_cnt   out  count of detected edges, wraps modulo 16
// ---------------------------------------------------------------------------
module clk_en_period_meter #(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 3,
    parameter int TIMEOUT  = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout_err,
    output logic [3:0]       strobe_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] GCNT_MAX    = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_V   = CNT_W'(TIMEOUT);
    localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_CNT - 1);

    state_t           state;
    logic             en_d;
    logic [CNT_W-1:0] gcnt;
    logic [CNT_W-1:0] ref_period;
    logic [3:0]       match_cnt;
    logic [3:0]       match_cnt_next;
    logic             strobe_edge;
    logic             is_match;

    // A level held high produces only one edge because en_d follows en_in.
    assign strobe_edge    = en_in & ~en_d;
    assign match_cnt_next = match_cnt + 4'd1;

`ifdef PERIOD_JITTER_TOL_EN
    // Tolerate one cycle of jitter in either direction around the reference.
    logic [CNT_W-1:0] gap_diff;
    assign gap_diff = (gcnt >= ref_period) ? (gcnt - ref_period) : (ref_period - gcnt);
    assign is_match = (gap_diff <= CNT_W'(1));
`else
    assign is_match = (gcnt == ref_period);
`endif

    // Single registered process: edge detect, gap counter, strobe counter and
    // the IDLE/MEASURE/LOCKED controller with its registered outputs.
    // An edge always takes priority over the timeout check, so a strobe that
    // arrives exactly at TIMEOUT is reported as a period of TIMEOUT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            en_d         <= 1'b0;
            gcnt         <= '0;
            ref_period   <= '0;
            match_cnt    <= 4'd0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout_err  <= 1'b0;
            strobe_cnt   <= 4'd0;
        end else begin
            en_d         <= en_in;
            period_valid <= 1'b0;
            timeout_err  <= 1'b0;

            if (strobe_edge) begin
                gcnt       <= CNT_W'(1);
                strobe_cnt <= strobe_cnt + 4'd1;
            end else if (gcnt != GCNT_MAX) begin
                gcnt <= gcnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    // First edge only arms the measurement; no period yet.
                    if (strobe_edge) begin
                        state     <= MEASURE;
                        match_cnt <= 4'd0;
                    end
                end

                MEASURE: begin
                    if (strobe_edge) begin
                        period       <= gcnt;
                        period_valid <= 1'b1;
                        if (is_match) begin
                            match_cnt <= match_cnt_next;
                            if (match_cnt_next == LOCK_TARGET) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            match_cnt  <= 4'd0;
                            ref_period <= gcnt;
                        end
                    end else if (gcnt == TIMEOUT_V) begin
                        timeout_err <= 1'b1;
                        locked      <= 1'b0;
                        state       <= IDLE;
                    end
                end

                LOCKED: begin
                    if (strobe_edge) begin
                        period       <= gcnt;
                        period_valid <= 1'b1;
                        if (!is_match) begin
                            locked     <= 1'b0;
                            state      <= MEASURE;
                            ref_period <= gcnt;
                            match_cnt  <= 4'd0;
                        end
                    end else if (gcnt == TIMEOUT_V) begin
                        timeout_err <= 1'b1;
                        locked      <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_en_period_meter.sv
// ---------------------------------------------------------------------------
// tb_clk_en_period_meter
//
// Purpose:
//   Self-checking bench for clk_en_period_meter. An event-level model keeps
//   the cycle number of the last rising edge, the lock reference and the
//   length of the current run of matching periods; it is compared against
//   the DUT on every falling clock edge. Directed scenarios pin the model
//   with hand-computed values, then a randomized phase mixes periods,
//   high widths, strobe losses and resets.
//
//   Honours PERIOD_JITTER_TOL_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_clk_en_period_meter;

    localparam int CNT_W    = 8;
    localparam int LOCK_CNT = 3;
    localparam int TIMEOUT  = 200;

    logic             clk;
    logic             rst_n;
    logic             en_in;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             timeout_err;
    logic [3:0]       strobe_cnt;

    int n_checks;
    int n_fail;

    clk_en_period_meter #(
        .CNT_W    (CNT_W),
        .LOCK_CNT (LOCK_CNT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_in        (en_in),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout_err  (timeout_err),
        .strobe_cnt   (strobe_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, expressed in terms of edge timestamps.
    int m_cyc;
    int m_last_edge;
    bit m_prev_en;
    bit m_active;
    int m_run;
    int m_ref;
    int m_period;
    bit m_pv;
    bit m_te;
    int m_cnt;
    bit m_valid;

    function automatic bit periods_match(input int gap, input int refv);
`ifdef PERIOD_JITTER_TOL_EN
        return (gap - refv <= 1) && (refv - gap <= 1);
`else
        return gap == refv;
`endif
    endfunction

    function automatic int m_locked();
        return (m_active && (m_run >= LOCK_CNT - 1)) ? 1 : 0;
    endfunction

    // Model update: one step per clock, reading the same inputs the DUT samples.
    always @(posedge clk) begin
        int gap;
        bit is_edge;
        if (!rst_n) begin
            m_prev_en = 1'b0;
            m_active  = 1'b0;
            m_run     = 0;
            m_ref     = 0;
            m_period  = 0;
            m_pv      = 1'b0;
            m_te      = 1'b0;
            m_cnt     = 0;
            m_valid   = 1'b1;
        end else begin
            is_edge = en_in && !m_prev_en;
            gap     = m_cyc - m_last_edge;
            m_pv    = 1'b0;
            m_te    = 1'b0;
            if (is_edge) begin
                m_cnt = (m_cnt + 1) % 16;
                if (m_active) begin
                    m_period = gap;
                    m_pv     = 1'b1;
                    if (periods_match(gap, m_ref)) begin
                        m_run = m_run + 1;
                    end else begin
                        m_run = 0;
                        m_ref = gap;
                    end
                end else begin
                    m_active = 1'b1;
                    m_run    = 0;
                end
                m_last_edge = m_cyc;
            end else if (m_active && gap == TIMEOUT) begin
                m_te     = 1'b1;
                m_active = 1'b0;
            end
            m_prev_en = en_in;
        end
        m_cyc = m_cyc + 1;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Pins both the DUT and the model against a hand-computed value.
    task automatic check_literal(input string name, input logic [31:0] dut_val,
                                 input int model_val, input int expected);
        check_output({name, "_dut"}, dut_val, expected);
        check_output({name, "_model"}, model_val, expected);
    endtask

    // Continuous comparison of all outputs against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check_output("period",       32'(period),       32'(m_period));
            check_output("period_valid", 32'(period_valid), 32'(m_pv));
            check_output("locked",       32'(locked),       32'(m_locked()));
            check_output("timeout_err",  32'(timeout_err),  32'(m_te));
            check_output("strobe_cnt",   32'(strobe_cnt),   32'(m_cnt));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Each strobe: low for p-w cycles, then high for w cycles. With a
    // constant w the edge-to-edge distance equals p.
    task automatic apply_stimulus(input int p, input int n, input int w);
        for (int i = 0; i < n; i++) begin
            en_in = 1'b0;
            tick(p - w);
            en_in = 1'b1;
            tick(w);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en_in = 1'b0;
        tick(3);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a randomized phase.
    initial begin
        int r;
        int p;
        n_checks    = 0;
        n_fail      = 0;
        m_valid     = 1'b0;
        m_cyc       = 0;
        m_last_edge = 0;
        rst_n       = 1'b0;
        en_in       = 1'b0;
        #2;
        do_reset();
        check_literal("rst_period", 32'(period), m_period, 0);
        check_literal("rst_cnt", 32'(strobe_cnt), m_cnt, 0);

        // Period 5 lock-in
        apply_stimulus(5, 1, 1);
        check_literal("t1_first_pv", 32'(period_valid), m_pv, 0);
        check_literal("t1_first_cnt", 32'(strobe_cnt), m_cnt, 1);
        apply_stimulus(5, 3, 1);
        check_literal("t1_period", 32'(period), m_period, 5);
        check_literal("t1_pv", 32'(period_valid), m_pv, 1);
        check_literal("t1_locked", 32'(locked), m_locked(), 1);
        check_literal("t1_cnt", 32'(strobe_cnt), m_cnt, 4);

        // Switch to period 7 while locked
        apply_stimulus(7, 1, 1);
        check_literal("t2_period", 32'(period), m_period, 7);
        check_literal("t2_unlock", 32'(locked), m_locked(), 0);
        apply_stimulus(7, 2, 1);
        check_literal("t2_relock", 32'(locked), m_locked(), 1);

        // Strobe loss while locked
        en_in = 1'b0;
        tick(TIMEOUT - 1);
        check_literal("t3_no_early_to", 32'(timeout_err), m_te, 0);
        tick(1);
        check_literal("t3_to", 32'(timeout_err), m_te, 1);
        check_literal("t3_to_unlock", 32'(locked), m_locked(), 0);
        check_literal("t3_to_period", 32'(period), m_period, 7);
        tick(1);
        check_literal("t3_to_pulse", 32'(timeout_err), m_te, 0);
        apply_stimulus(6, 1, 1);
        check_literal("t3_rearm_pv", 32'(period_valid), m_pv, 0);
        apply_stimulus(6, 1, 1);
        check_literal("t3_new_period", 32'(period), m_period, 6);
        check_literal("t3_new_pv", 32'(period_valid), m_pv, 1);

        // Long high level is a single edge
        en_in = 1'b0;
        tick(3);
        en_in = 1'b1;
        tick(10);
        en_in = 1'b0;
        tick(3);
        check_literal("t4_cnt", 32'(strobe_cnt), m_cnt, 10);
        check_literal("t4_period", 32'(period), m_period, 4);

        // Strobe counter wrap and mid-lock reset
        do_reset();
        apply_stimulus(5, 17, 1);
        check_literal("t5_wrap", 32'(strobe_cnt), m_cnt, 1);
        check_literal("t5_locked", 32'(locked), m_locked(), 1);
        rst_n = 1'b0;
        en_in = 1'b0;
        tick(1);
        check_literal("t5_rst_period", 32'(period), m_period, 0);
        check_literal("t5_rst_locked", 32'(locked), m_locked(), 0);
        check_literal("t5_rst_cnt", 32'(strobe_cnt), m_cnt, 0);
        rst_n = 1'b1;
        apply_stimulus(5, 1, 1);
        check_literal("t5_idle_pv", 32'(period_valid), m_pv, 0);

        // Jittered periods 5, 6, 5, 5
        do_reset();
        apply_stimulus(5, 2, 1);
        apply_stimulus(6, 1, 1);
        apply_stimulus(5, 2, 1);
        check_literal("t6_period", 32'(period), m_period, 5);
        check_literal("t6_cnt", 32'(strobe_cnt), m_cnt, 5);
`ifdef PERIOD_JITTER_TOL_EN
        check_literal("t6_locked", 32'(locked), m_locked(), 1);
`else
        check_literal("t6_locked", 32'(locked), m_locked(), 0);
`endif

        // Edge landing exactly on the timeout count wins
        do_reset();
        apply_stimulus(5, 3, 1);
        apply_stimulus(TIMEOUT, 1, 1);
        check_literal("t7_period", 32'(period), m_period, TIMEOUT);
        check_literal("t7_pv", 32'(period_valid), m_pv, 1);
        check_literal("t7_no_to", 32'(timeout_err), m_te, 0);

        // Randomized phase
        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                rst_n = 1'b0;
                en_in = 1'($urandom_range(0, 1));
                tick($urandom_range(1, 3));
                rst_n = 1'b1;
            end else if (r <= 3) begin
                apply_stimulus($urandom_range(TIMEOUT - 5, TIMEOUT + 5), 1, 1);
            end else if (r <= 10) begin
                p = $urandom_range(2, 9);
                apply_stimulus(p, $urandom_range(1, 6), 1);
            end else begin
                p = $urandom_range(2, 9);
                apply_stimulus(p, $urandom_range(1, 6), $urandom_range(1, p - 1));
            end
        end

        en_in = 1'b0;
        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
